// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    // Controller states; encodings are fixed and must not be reordered.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Supported operand width range.
    localparam int unsigned WIDTH_MIN = 32'd1;
    localparam int unsigned WIDTH_MAX = 32'd32;

    // True when w is a supported operand width.
    function automatic logic width_legal(input int unsigned w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/done handshake bundle between the serial adder and its client.
interface serial_adder_if #(parameter int WIDTH = 8);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             done_valid;
    logic             done_ready;
    logic [WIDTH-1:0] sum_out;
    logic             cout;

    // Client side: presents operands, consumes results.
    modport master (
        output start_valid, a_in, b_in, cin, done_ready,
        input  start_ready, done_valid, sum_out, cout
    );

    // Adder side.
    modport slave (
        input  start_valid, a_in, b_in, cin, done_ready,
        output start_ready, done_valid, sum_out, cout
    );
endinterface

// File: rtl/half_adder.sv
// Existing one-bit half adder cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/serial_adder_full_adder.sv
// One-bit full-adder slice built from two half adders and an OR.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s1_s;
    logic c1_s;
    logic c2_s;

    half_adder u_ha0 (.a(a),    .b(b),   .s(s1_s), .c(c1_s));
    half_adder u_ha1 (.a(s1_s), .b(cin), .s(s),    .c(c2_s));

    assign cout = c1_s | c2_s;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice, LSB first, WIDTH clocks per sum.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (!width_legal(WIDTH)) begin : g_bad_width
        $error("serial_adder: WIDTH must be within 1..32");
    end

    state_e           state_r;
    state_e           state_nxt_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] sum_sh_r;
    logic [WIDTH-1:0] sum_nxt_s;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;
    logic             s_bit_s;
    logic             c_bit_s;
    logic             start_hs_s;
    logic             done_hs_s;

    full_adder u_slice (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .cin  (carry_r),
        .s    (s_bit_s),
        .cout (c_bit_s)
    );

    // Handshakes qualify on registered state only, never on outputs.
    assign start_hs_s = bus.start_valid && (state_r == ST_IDLE);
    assign done_hs_s  = bus.done_ready  && (state_r == ST_DONE);

    assign bus.start_ready = (state_r == ST_IDLE);
    assign bus.done_valid  = (state_r == ST_DONE);
    assign bus.sum_out     = sum_sh_r;
    assign bus.cout        = carry_r;

    // New sum bit enters at the MSB end so bit 0 lands in place after WIDTH shifts.
    always_comb begin
        sum_nxt_s = sum_sh_r >> 1;
        sum_nxt_s[WIDTH-1] = s_bit_s;
    end

    // Next-state decode for the IDLE/RUN/DONE controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_hs_s) state_nxt_s = ST_RUN;
                else            state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (cnt_r == CNT_LAST) state_nxt_s = ST_DONE;
                else                   state_nxt_s = ST_RUN;
            end
            ST_DONE: begin
                if (done_hs_s) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nxt_s;
    end

    // Operand/sum shifters, carry flip-flop and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            sum_sh_r <= '0;
            carry_r  <= 1'b0;
            cnt_r    <= '0;
        end else if (start_hs_s) begin
            a_sh_r  <= bus.a_in;
            b_sh_r  <= bus.b_in;
            carry_r <= bus.cin;
            cnt_r   <= '0;
        end else if (state_r == ST_RUN) begin
            a_sh_r   <= a_sh_r >> 1;
            b_sh_r   <= b_sh_r >> 1;
            sum_sh_r <= sum_nxt_s;
            carry_r  <= c_bit_s;
            cnt_r    <= cnt_r + CNT_W'(1);
        end else begin
            a_sh_r   <= a_sh_r;
            b_sh_r   <= b_sh_r;
            sum_sh_r <= sum_sh_r;
            carry_r  <= carry_r;
            cnt_r    <= cnt_r;
        end
    end

endmodule
